// File: rtl/nibble_stream_feeder.sv
// nibble_stream_feeder: serializes 16-bit words into nibbles for the skew chain, then drains it with zeros.
// Build option FEEDER_MSB_FIRST_EN emits each word's nibbles MSB first instead of LSB first.
module nibble_stream_feeder #(
    parameter int SA_NUM = 4,
    parameter int WORD_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [3:0]        nib_out,
    output logic              nib_valid,
    output logic              busy,
    output logic              done
);
    localparam int DRAIN_LEN = (SA_NUM - 1) * 4;
    localparam int DW        = $clog2(DRAIN_LEN) + 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  words_left_q;
    logic [WORD_W-1:0] hold_q;
    logic [1:0]        nidx_q;
    logic              full_q;
    logic [DW-1:0]     drain_q;
    logic [3:0]        nib_q;
    logic              nib_valid_q;
    logic [3:0]        nib_d;
    logic [1:0]        sel;
    logic              xfer;
    logic              last_nib;

    // A new word may land on the same edge the current word's last nibble leaves.
    assign in_ready  = state_q == STREAM && words_left_q != '0 && (!full_q || nidx_q == 2'd3);
    assign xfer      = in_valid && in_ready;
    assign last_nib  = full_q && nidx_q == 2'd3 && words_left_q == '0;
    assign busy      = state_q == STREAM || state_q == DRAIN;
    assign done      = state_q == DONE;
    assign nib_out   = nib_q;
    assign nib_valid = nib_valid_q;

`ifdef FEEDER_MSB_FIRST_EN
    assign sel = ~nidx_q;
`else
    assign sel = nidx_q;
`endif
    assign nib_d = hold_q[{sel, 2'b00} +: 4];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            words_left_q <= '0;
            hold_q       <= '0;
            nidx_q       <= '0;
            full_q       <= 1'b0;
            drain_q      <= '0;
            nib_q        <= '0;
            nib_valid_q  <= 1'b0;
        end else begin
            nib_q       <= '0;
            nib_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        words_left_q <= num_words;
                        drain_q      <= '0;
                        state_q      <= num_words != '0 ? STREAM : DRAIN;
                    end
                end
                STREAM: begin
                    if (full_q) begin
                        nib_q       <= nib_d;
                        nib_valid_q <= 1'b1;
                    end
                    if (xfer) begin
                        hold_q       <= in_data;
                        full_q       <= 1'b1;
                        nidx_q       <= '0;
                        words_left_q <= words_left_q - CNT_W'(1);
                    end else if (full_q) begin
                        nidx_q <= nidx_q + 2'd1;
                        full_q <= nidx_q != 2'd3;
                    end
                    state_q <= last_nib ? DRAIN : STREAM;
                end
                DRAIN: begin
                    drain_q <= drain_q + DW'(1);
                    state_q <= drain_q == DW'(DRAIN_LEN - 1) ? DONE : DRAIN;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/nibble_stream_feeder.md
Name: nibble_stream_feeder

Overview:
- Upstream feeder for the 4-bit systolic skew shift chain. Accepts 16-bit words from the operand buffer over a valid/ready handshake and serializes each word into four 4-bit nibbles, one per clock.
- Drives the chain's 4-bit input, which shifts every cycle. Bubbles are therefore emitted as zero nibbles.
- After the programmed number of words, pushes (SA_NUM-1)*4 zero nibbles to flush the chain, then pulses done.

Parameters:
SA_NUM, 4, number of systolic array columns; drain length = (SA_NUM-1)*4 cycles
WORD_W, 16, input word width; fixed at 16 (4 nibbles per word); other values unsupported
CNT_W, 16, width of the word-count register

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse; begins a job; sampled only in IDLE
num_words  input  CNT_W  words in the job; sampled with start
in_data  input  16  word from operand buffer
in_valid  input  1  in_data valid
in_ready  output  1  feeder can accept in_data this cycle
nib_out  output  4  nibble to skew shift chain (registered)
nib_valid  output  1  nib_out carries real data (0 = bubble/drain zero)
busy  output  1  high in STREAM and DRAIN
done  output  1  one-cycle pulse on job completion

Behaviour:
- Reset (async, rstn=0) values: state=IDLE, nib_out=0, nib_valid=0, in_ready=0, busy=0, done=0. All counters and the holding register are cleared and marked empty.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 with num_words>0: latch num_words as words_left and go to STREAM.
  - start=1 with num_words=0: go directly to DRAIN.
- STREAM:
  - Holding register hold[15:0] has nibble index nidx[1:0] and a full flag.
  - in_ready = (words_left>0) && (!full || nidx==3).
  - A transfer occurs when in_valid && in_ready. On transfer: load hold, set full, nidx=0, decrement words_left.
- Output register update each cycle:
  - full: nib_out=hold[4*nidx +: 4], nib_valid=1, then nidx++.
  - After nidx==3 is emitted, full clears unless a new word is loaded in the same cycle. That gives back-to-back words with no bubble.
  - Not full (underflow): nib_out=0, nib_valid=0. Bubbles cost one cycle each and do not count toward the drain.
- Latency: a word accepted on edge N appears as nibble 0 on nib_out after edge N+1. Its four nibbles occupy edges N+1..N+4.
- STREAM to DRAIN: occurs on the cycle the last nibble of the last word is emitted (words_left==0 and that nibble is nidx==3).
- DRAIN:
  - drain_cnt counts (SA_NUM-1)*4 cycles with nib_out=0, nib_valid=0, in_ready=0.
  - When the count completes, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- busy=1 exactly while state is STREAM or DRAIN.
- start while not in IDLE (including DONE) is ignored; num_words is not re-sampled.
- in_valid while in_ready=0 is ignored. The source must hold in_data/in_valid (standard valid/ready).
- Mid-job rstn assertion aborts immediately to reset values. No done pulse is generated.
- words_left never underflows; in_ready=0 once words_left==0.

Optional Feature:
- Macro: FEEDER_MSB_FIRST_EN.
- Defined: nibbles are emitted MSB first, i.e. hold[15:12], [11:8], [7:4], [3:0].
- Undefined (default): nibbles are emitted LSB first, i.e. hold[3:0], [7:4], [11:8], [15:12].
- Timing, handshake and drain are identical in both builds.

Test Plan:
- Reset/idle: assert rstn=0 mid-cycle -> all outputs 0 asynchronously; hold start=0 for 10 cycles -> nib_out=0, busy=0, in_ready=0.
- Single word: start with num_words=1, in_data=0xA5C3 held valid -> nib_out 3,C,5,A on 4 consecutive cycles with nib_valid=1 (0xA,0x5,0xC,0x3 if FEEDER_MSB_FIRST_EN) -> 12 zero cycles (SA_NUM=4) -> done pulse -> IDLE.
- Back-to-back: num_words=3, in_valid always 1 with words 0x1111, 0x2222, 0x3333 -> 12 consecutive valid nibbles with no bubble; in_ready high on nibble-3 cycles only after the first load; then 12 drain cycles and done.
- Underflow: num_words=2, second word presented 5 cycles after first completes -> 5 bubble cycles (nib_out=0, nib_valid=0) between nibble groups; drain still exactly 12 cycles.
- Zero-length and ignored start: num_words=0 -> in_ready never high, 12 drain cycles, done. A start pulse during DRAIN -> no effect on timing or num_words.
- Reset mid-job: rstn=0 during word 2 nibble 1 of a 4-word job -> immediate IDLE, no done. A subsequent start with num_words=1 runs cleanly.
